// File: rtl/t_to_s_stream_if.sv
// Valid/ready stream bundle for the two's complement to sign-magnitude converter.
interface t_to_s_stream_if #(
  parameter int W = 5
) ();
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/t_to_s_stream.sv
// Two's complement to sign-magnitude stream converter with a 2-entry skid buffer.
// Optional saturation event counter enabled by defining T_TO_S_SAT_CNT_EN.
module t_to_s_stream #(
  parameter int W     = 5,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  t_to_s_stream_if.slave     s_bus,
  input  logic               sat_clr,
  output logic [CNT_W-1:0]   sat_cnt
);

  localparam logic signed [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  // The most negative input has no sign-magnitude counterpart; clamp to -(2^(W-1)-1).
  function automatic logic [W-1:0] to_sm(input logic signed [W-1:0] x);
    logic signed [W-1:0] neg;
    neg = -x;
    if (x >= 0)
      to_sm = $unsigned(x);
    else if (x == MOST_NEG)
      to_sm = {W{1'b1}};
    else
      to_sm = {1'b1, neg[W-2:0]};
  endfunction

  logic signed [W-1:0] w_in_s;
  logic [W-1:0]        w_conv;
  logic                w_sat;
  logic                w_acc;
  logic                w_pop;
  logic [1:0]          w_state;

  logic [W-1:0]        r_out_data;
  logic                r_out_vld;
  logic [W-1:0]        r_skid_data;
  logic                r_skid_vld;
  logic                r_in_ready;

  assign w_in_s  = s_bus.in_data;
  assign w_conv  = to_sm(w_in_s);
  assign w_sat   = (w_in_s == MOST_NEG);
  assign w_acc   = s_bus.in_valid & r_in_ready;
  assign w_pop   = r_out_vld & s_bus.out_ready;
  assign w_state = {r_skid_vld, r_out_vld};

  // Stage boundary: OUT/SKID slots; in_ready is registered as "SKID empty".
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_data <= '0;
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      case (w_state)
        ST_EMPTY: begin
          if (w_acc) begin
            r_out_data <= w_conv;
            r_out_vld  <= 1'b1;
          end
        end
        ST_ONE: begin
          if (w_acc && w_pop) begin
            r_out_data <= w_conv;
          end else if (w_acc) begin
            r_skid_data <= w_conv;
            r_skid_vld  <= 1'b1;
            r_in_ready  <= 1'b0;
          end else if (w_pop) begin
            r_out_vld <= 1'b0;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            r_out_data <= r_skid_data;
            r_skid_vld <= 1'b0;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_skid_vld <= 1'b0;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign s_bus.out_data  = r_out_data;
  assign s_bus.out_valid = r_out_vld;
  assign s_bus.in_ready  = r_in_ready;

`ifdef T_TO_S_SAT_CNT_EN
  logic [CNT_W-1:0] r_sat_cnt;

  // Clear wins over increment; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_sat_cnt <= '0;
    else if (sat_clr)
      r_sat_cnt <= '0;
    else if (w_acc && w_sat && (r_sat_cnt != {CNT_W{1'b1}}))
      r_sat_cnt <= r_sat_cnt + 1'b1;
  end

  assign sat_cnt = r_sat_cnt;
`else
  logic w_unused_sat;
  assign w_unused_sat = sat_clr ^ w_sat;
  assign sat_cnt      = '0;
`endif

endmodule

// File: tb/tb_t_to_s_stream.sv
// Self-checking bench for t_to_s_stream: vector table, corner sequences, random stream vs model.
module tb_t_to_s_stream;

  localparam int TW = 5;
`ifdef T_TO_S_SAT_CNT_EN
  localparam int SAT_EN = 1;
`else
  localparam int SAT_EN = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        sat_clr;
  logic [7:0]  sat_cnt;
  logic        sat_clr2;
  logic [1:0]  sat_cnt2;

  t_to_s_stream_if #(.W(TW)) ifc ();
  t_to_s_stream_if #(.W(TW)) if2 ();

  t_to_s_stream #(.W(TW), .CNT_W(8)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_bus   (ifc.slave),
    .sat_clr (sat_clr),
    .sat_cnt (sat_cnt)
  );

  t_to_s_stream #(.W(TW), .CNT_W(2)) u_dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_bus   (if2.slave),
    .sat_clr (sat_clr2),
    .sat_cnt (sat_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [TW-1:0] din;
    logic [TW-1:0] dout;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference mapping from numeric value: clamp magnitude, then pack sign and magnitude.
  function automatic logic [TW-1:0] ref_conv(input logic [TW-1:0] x);
    int v;
    int mag;
    v = int'($signed(x));
    if (v >= 0) return x;
    mag = -v;
    if (mag > (1 << (TW - 1)) - 1) mag = (1 << (TW - 1)) - 1;
    return TW'((1 << (TW - 1)) + mag);
  endfunction

  function automatic int exp_cnt(input int n, input int max_v);
    if (SAT_EN == 0) return 0;
    return (n > max_v) ? max_v : n;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [TW-1:0] q[$];
    logic [TW-1:0] exp_w;
    int n_in, n_out, n_sat, cyc, seen;
    logic acc, pop;

    vecs[0] = '{5'b00000, 5'b00000};
    vecs[1] = '{5'b00111, 5'b00111};
    vecs[2] = '{5'b01111, 5'b01111};
    vecs[3] = '{5'b11010, 5'b10110};
    vecs[4] = '{5'b11111, 5'b10001};
    vecs[5] = '{5'b10001, 5'b11111};

    rst_n = 1'b0; sat_clr = 1'b0; sat_clr2 = 1'b0;
    ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.out_ready = 1'b1;
    if2.in_valid = 1'b0; if2.in_data = '0; if2.out_ready = 1'b1;
    step(); step();
    rst_n = 1'b1;

    check("rst_out_valid", 32'(ifc.out_valid), 0);
    check("rst_out_data",  32'(ifc.out_data), 0);
    check("rst_in_ready",  32'(ifc.in_ready), 1);
    check("rst_sat_cnt",   32'(sat_cnt), 0);

    // Value mapping: each word visible one cycle after acceptance
    for (int i = 0; i < 6; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_data  = vecs[i].din;
      step();
      check($sformatf("map_valid[%0d]", i), 32'(ifc.out_valid), 1);
      check($sformatf("map_data[%0d]", i),  32'(ifc.out_data), 32'(vecs[i].dout));
    end
    ifc.in_valid = 1'b0;
    step();
    check("map_drain_valid", 32'(ifc.out_valid), 0);

    // Saturation and counter clear
    for (int k = 1; k <= 3; k++) begin
      ifc.in_valid = 1'b1;
      ifc.in_data  = 5'b10000;
      step();
      check($sformatf("sat_data[%0d]", k), 32'(ifc.out_data), 32'h1f);
      check($sformatf("sat_cnt[%0d]", k),  32'(sat_cnt), 32'(exp_cnt(k, 255)));
    end
    ifc.in_valid = 1'b0;
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    check("sat_cnt_clr", 32'(sat_cnt), 0);
    ifc.in_valid = 1'b1;
    ifc.in_data  = 5'b10000;
    step();
    ifc.in_valid = 1'b0;
    check("sat_data_after_clr", 32'(ifc.out_data), 32'h1f);
    check("sat_cnt_after_clr",  32'(sat_cnt), 32'(exp_cnt(1, 255)));
    step();

    // Counter hold at all-ones on the narrow-counter instance
    for (int k = 1; k <= 5; k++) begin
      if2.in_valid = 1'b1;
      if2.in_data  = 5'b10000;
      step();
      check($sformatf("hold_cnt[%0d]", k), 32'(sat_cnt2), 32'(exp_cnt(k, 3)));
    end
    if2.in_valid = 1'b0;

    // Backpressure: two words accepted, third held off until a pop
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    ifc.in_data   = 5'b00001;
    step();
    check("bp_first_out",   32'(ifc.out_data), 32'h01);
    check("bp_first_ready", 32'(ifc.in_ready), 1);
    ifc.in_data = 5'b00010;
    step();
    check("bp_second_ready", 32'(ifc.in_ready), 0);
    check("bp_second_out",   32'(ifc.out_data), 32'h01);
    ifc.in_data = 5'b00011;
    step();
    step();
    check("bp_stall_ready", 32'(ifc.in_ready), 0);
    check("bp_stall_out",   32'(ifc.out_data), 32'h01);
    check("bp_stall_valid", 32'(ifc.out_valid), 1);
    ifc.out_ready = 1'b1;
    step();
    check("bp_pop1_out",   32'(ifc.out_data), 32'h02);
    check("bp_pop1_ready", 32'(ifc.in_ready), 1);
    step();
    ifc.in_valid = 1'b0;
    check("bp_pop2_out",   32'(ifc.out_data), 32'h03);
    check("bp_pop2_valid", 32'(ifc.out_valid), 1);
    step();
    check("bp_empty_valid", 32'(ifc.out_valid), 0);

    // Reset while FULL
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    ifc.in_data   = 5'b10000;
    step();
    ifc.in_data = 5'b00101;
    step();
    check("rm_full_ready", 32'(ifc.in_ready), 0);
    ifc.in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rm_out_valid", 32'(ifc.out_valid), 0);
    check("rm_in_ready",  32'(ifc.in_ready), 1);
    check("rm_sat_cnt",   32'(sat_cnt), 0);
    ifc.out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (ifc.out_valid) seen++;
    end
    check("rm_no_stale", 32'(seen), 0);

    // Random stream against a queue model of buffered words
    n_in = 0; n_out = 0; n_sat = 0; cyc = 0;
    while (n_in < 1000 && cyc < 20000) begin
      check("rnd_out_valid", 32'(ifc.out_valid), 32'(q.size() > 0));
      check("rnd_in_ready",  32'(ifc.in_ready),  32'(q.size() < 2));
      ifc.in_valid  = ($urandom_range(0, 9) < 7);
      ifc.in_data   = TW'($urandom);
      ifc.out_ready = ($urandom_range(0, 9) < 7);
      acc = ifc.in_valid && ifc.in_ready;
      pop = ifc.out_valid && ifc.out_ready;
      if (pop) begin
        exp_w = (q.size() > 0) ? q.pop_front() : 'x;
        check("rnd_data",    32'(ifc.out_data), 32'(exp_w));
        check("rnd_neg_zero", 32'(ifc.out_data == 5'b10000), 0);
        n_out++;
      end
      if (acc) begin
        q.push_back(ref_conv(ifc.in_data));
        if (ifc.in_data == 5'b10000) n_sat++;
        n_in++;
      end
      step();
      cyc++;
    end
    check("rnd_input_budget", 32'(n_in), 1000);
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    cyc = 0;
    while (q.size() > 0 && cyc < 10) begin
      if (ifc.out_valid) begin
        exp_w = q.pop_front();
        check("drain_data", 32'(ifc.out_data), 32'(exp_w));
        n_out++;
      end
      step();
      cyc++;
    end
    check("drain_empty",  32'(q.size()), 0);
    check("drain_valid",  32'(ifc.out_valid), 0);
    check("count_in_out", 32'(n_out), 32'(n_in));
    check("rnd_sat_cnt",  32'(sat_cnt), 32'(exp_cnt(n_sat, 255)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
